// File: rtl/rede_neuron_core.sv
// Single-neuron fixed-point inference core: requests four samples per frame, accumulates
// weighted products, then scales, saturates, optionally rectifies and publishes one word.
module rede_neuron_core #(
    parameter logic signed [30:0] W0   = 31'sd1024,
    parameter logic signed [30:0] W1   = -31'sd512,
    parameter logic signed [30:0] W2   = 31'sd2048,
    parameter logic signed [30:0] W3   = 31'sd256,
    parameter logic signed [30:0] B    = 31'sd0,
    parameter int                 FRAC = 10,
    parameter bit                 RELU = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [30:0] io_in,
    output logic signed [30:0] io_out,
    output logic [3:0]         req_in,
    output logic [3:0]         out_en,
    output logic [1:0]         dbg_state_o
);

    // Handshake: req_in is 4'd1 for one cycle; the producer drives io_in during the
    // following cycle and the core samples it on the edge ending that cycle. out_en is
    // 4'd1 for one cycle when io_out carries a fresh result; io_out then holds.
    typedef enum logic [1:0] {
        ST_REQ = 2'd0,
        ST_CAP = 2'd1,
        ST_ACT = 2'd2,
        ST_OUT = 2'd3
    } state_t;

    localparam logic signed [63:0] SAT_MAX = 64'sd1073741823;
    localparam logic signed [63:0] SAT_MIN = -64'sd1073741824;

    state_t             state_q;
    logic [1:0]         k_q;
    logic               cap_q;
    logic signed [63:0] acc_q;
    logic signed [30:0] io_out_q;
    logic [3:0]         req_q;
    logic [3:0]         out_en_q;

    logic signed [30:0] weight_sel;
    logic signed [61:0] w_ext;
    logic signed [61:0] x_ext;
    logic signed [61:0] prod;
    logic signed [63:0] acc_next;
    logic signed [63:0] shifted;
    logic signed [63:0] biased;
    logic signed [30:0] y_sat;
    logic signed [30:0] y_act;

    always_comb begin
        weight_sel = W0;
        case (k_q)
            2'd0:    weight_sel = W0;
            2'd1:    weight_sel = W1;
            2'd2:    weight_sel = W2;
            default: weight_sel = W3;
        endcase
    end

    // Both operands are sign-extended to the full product width, so the truncated
    // 62-bit multiply is the exact signed product.
    assign w_ext    = {{31{weight_sel[30]}}, weight_sel};
    assign x_ext    = {{31{io_in[30]}}, io_in};
    assign prod     = w_ext * x_ext;
    assign acc_next = acc_q + {{2{prod[61]}}, prod};

    assign shifted  = acc_q >>> FRAC;
    assign biased   = shifted + {{33{B[30]}}, B};

    always_comb begin
        y_sat = biased[30:0];
        if (biased > SAT_MAX) begin
            y_sat = SAT_MAX[30:0];
        end else if (biased < SAT_MIN) begin
            y_sat = SAT_MIN[30:0];
        end
        y_act = y_sat;
        if (RELU && y_sat[30]) begin
            y_act = '0;
        end
    end

    // state_q names the phase whose registered outputs launch on the next edge; the
    // sample requested in a CAP phase is folded in one edge later, tracked by cap_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_REQ;
            k_q      <= 2'd0;
            cap_q    <= 1'b0;
            acc_q    <= '0;
            io_out_q <= '0;
            req_q    <= 4'd0;
            out_en_q <= 4'd0;
        end else begin
            req_q    <= 4'd0;
            out_en_q <= 4'd0;
            if (cap_q) begin
                acc_q <= acc_next;
                k_q   <= k_q + 2'd1;
                cap_q <= 1'b0;
            end
            case (state_q)
                ST_REQ: begin
                    req_q   <= 4'd1;
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    cap_q   <= 1'b1;
                    state_q <= (k_q == 2'd3) ? ST_ACT : ST_REQ;
                end
                ST_ACT: begin
                    state_q <= ST_OUT;
                end
                default: begin
                    io_out_q <= y_act;
                    out_en_q <= 4'd1;
                    acc_q    <= '0;
                    k_q      <= 2'd0;
                    state_q  <= ST_REQ;
                end
            endcase
        end
    end

    assign io_out      = io_out_q;
    assign req_in      = req_q;
    assign out_en      = out_en_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rede_neuron_core.sv
// Directed-vector bench for rede_neuron_core: RELU=1 and RELU=0 instances share the input
// bus; expected results are queued per frame and a monitor checks every output strobe.
module tb_rede_neuron_core;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [30:0] io_in = '0;
  logic signed [30:0] io_out1, io_out0;
  logic [3:0]         req1, req0, oe1, oe0;
  logic [1:0]         st1, st0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [30:0] exp_q1[$];
  logic [30:0] exp_q0[$];

  int vx[10][4];
  int ve1[10];
  int ve0[10];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  rede_neuron_core #(.RELU(1'b1)) dut1 (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out1),
    .req_in(req1), .out_en(oe1), .dbg_state_o(st1)
  );

  rede_neuron_core #(.RELU(1'b0)) dut0 (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out0),
    .req_in(req0), .out_en(oe0), .dbg_state_o(st0)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic set_vec(input int idx, input int a, input int b, input int c, input int d,
                         input int e_relu, input int e_lin);
    vx[idx][0] = a;
    vx[idx][1] = b;
    vx[idx][2] = c;
    vx[idx][3] = d;
    ve1[idx]   = e_relu;
    ve0[idx]   = e_lin;
  endtask

  // ---------------- driver ----------------
  task automatic drive_input(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req1 != 4'd1 && n < 30);
    if (req1 != 4'd1) check("req_timeout", 0, 1);
    @(posedge clk);
    #1 io_in = 31'(v);
  endtask

  task automatic run_frame(input int idx);
    exp_q1.push_back(31'(ve1[idx]));
    exp_q0.push_back(31'(ve0[idx]));
    for (int i = 0; i < 4; i++) drive_input(vx[idx][i]);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic signed [30:0] last1, last0, e;
    last1 = '0;
    last0 = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last1 = '0;
        last0 = '0;
      end else begin
        check("req_out_exclusive", longint'(req1 != 4'd0 && oe1 != 4'd0), 0);
        check("req_range", longint'(req1 <= 4'd1 && oe1 <= 4'd1), 1);
        if (req1 == 4'd1) check("req_phase", longint'((cyc % 10) inside {1, 3, 5, 7}), 1);
        if (oe1 == 4'd1) begin
          check("out_en_phase", cyc % 10, 0);
          if (exp_q1.size() == 0) begin
            check("unexpected_out_relu1", 1, 0);
          end else begin
            e = exp_q1.pop_front();
            check("io_out_relu1", io_out1, e);
            last1 = e;
          end
        end else begin
          check("hold_relu1", io_out1, last1);
        end
        if (oe0 == 4'd1) begin
          if (exp_q0.size() == 0) begin
            check("unexpected_out_relu0", 1, 0);
          end else begin
            e = exp_q0.pop_front();
            check("io_out_relu0", io_out0, e);
            last0 = e;
          end
        end else begin
          check("hold_relu0", io_out0, last0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    set_vec(0, 1024, 1024, 1024, 1024, 2816, 2816);
    set_vec(1, 0, 4096, 0, 0, 0, -2048);
    set_vec(2, 0, 0, 1073741823, 0, 1073741823, 1073741823);
    set_vec(3, 0, 1073741823, 0, 0, 0, -536870912);
    set_vec(4, 1, 0, 0, 0, 1, 1);
    set_vec(5, 0, 1, 0, 0, 0, -1);
    set_vec(6, 0, 0, 0, 3, 0, 0);
    set_vec(7, 0, 0, -1073741824, 0, 0, -1073741824);
    set_vec(8, -1, 0, 0, 0, 0, -1);
    set_vec(9, -5, 7, -3, 100, 10, 10);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_io_out1", io_out1, 0);
    check("reset_io_out0", io_out0, 0);
    check("reset_req", req1, 0);
    check("reset_out_en", oe1, 0);
    check("reset_state", st1, 0);

    @(negedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) run_frame(i);

    // Abort a frame while input 2 is on the bus.
    drive_input(1024);
    drive_input(1024);
    drive_input(1024);
    #2 rst = 1'b0;
    #1;
    check("midreset_io_out1", io_out1, 0);
    check("midreset_io_out0", io_out0, 0);
    check("midreset_req", req1, 0);
    check("midreset_out_en", oe1, 0);
    check("midreset_state", st1, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    run_frame(0);

    n = 0;
    while ((exp_q1.size() != 0 || exp_q0.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check("drain_relu1", exp_q1.size(), 0);
    check("drain_relu0", exp_q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
